// File: rtl/nor_mis_stim_sequencer.sv
// Multiple-input-switching stimulus sequencer for the NOR2 delay-measurement chain.
// Drives myinA1/myinA2 with a programmable inter-input skew, sweeps the skew, and
// reports one synchronized latency measurement per skew point over valid/ready.
module nor_mis_stim_sequencer #(
  parameter int SKEW_W     = 8,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SKEW_W-1:0] cfg_skew_min,
  input  logic [SKEW_W-1:0] cfg_skew_max,
  input  logic [SKEW_W-1:0] cfg_skew_step,
  input  logic              cfg_a1_lead,
  input  logic              cfg_rise,
  input  logic              dut_out,
  output logic              myinA1,
  output logic              myinA2,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SKEW_W-1:0] res_skew,
  output logic [CNT_W-1:0]  res_lat,
  output logic              res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LEAD, S_SKEW, S_MEAS, S_REPORT, S_FIN
  } state_t;

  state_t state, state_nx;

  // Latched sweep configuration
  logic [SKEW_W-1:0] skew, skew_max, skew_step;
  logic              a1_lead, rise;

  logic [CNT_W-1:0]  cnt;
  logic              hit;
  logic              sync1, sync2;

  logic              a1_nx, a2_nx;
  logic              rise_eff, idle_lvl;
  logic              lead_lvl, lag_lvl;
  logic              lead_nx, lag_nx;
  logic              lag_driven, lag_fire;
  logic              monitor, hit_now, cnt_max, cnt_clr;
  logic              drive_idle, sweep_end;
  logic [CNT_W:0]    cnt_inc, skew_ext;
  logic [SKEW_W:0]   next_skew;

  // Lead/lag view of the two chain inputs, selected by the latched lead choice.
  // In IDLE the live cfg is used so the first settle level is right on the start edge.
  always_comb begin
    rise_eff   = (state == S_IDLE) ? cfg_rise : rise;
    idle_lvl   = ~rise_eff;
    lead_lvl   = a1_lead ? myinA1 : myinA2;
    lag_lvl    = a1_lead ? myinA2 : myinA1;
    lag_driven = (lag_lvl == rise);
    cnt_inc    = {1'b0, cnt} + (CNT_W+1)'(1);
    skew_ext   = (CNT_W+1)'(skew);
    cnt_max    = (cnt == CNT_W'(TIMEOUT));
    lag_fire   = ((state == S_LEAD) || (state == S_SKEW)) && !lag_driven && (cnt_inc == skew_ext);
    monitor    = (state == S_SKEW) || (state == S_MEAS);
    // Expected output level equals the idle input level (~cfg_rise)
    hit_now    = monitor && !hit && (sync2 == ~rise);
    next_skew  = {1'b0, skew} + {1'b0, skew_step};
    sweep_end  = (skew_step == '0) || (next_skew > {1'b0, skew_max}) || next_skew[SKEW_W];
  end

  // Next-state logic for the sweep sequencer
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = (cfg_skew_min > cfg_skew_max) ? S_FIN : S_SETTLE;
      S_SETTLE: if (cnt == CNT_W'(SETTLE_CYC - 1)) state_nx = S_LEAD;
      S_LEAD:   state_nx = (skew == '0) ? S_MEAS : S_SKEW;
      S_SKEW:   if (lag_fire || lag_driven) state_nx = S_MEAS;
      S_MEAS:   if (hit || hit_now || cnt_max) state_nx = S_REPORT;
      S_REPORT: if (res_valid && res_ready) state_nx = sweep_end ? S_FIN : S_SETTLE;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Next values of the chain inputs; each input changes at most once per phase
  always_comb begin
    drive_idle = ((state_nx == S_SETTLE) && (state != S_SETTLE)) ||
                 ((state_nx == S_FIN) && (state != S_FIN));
    cnt_clr    = ((state_nx == S_SETTLE) && (state != S_SETTLE)) || (state_nx == S_LEAD);
    lead_nx    = lead_lvl;
    lag_nx     = lag_lvl;
    if (drive_idle) begin
      lead_nx = idle_lvl;
      lag_nx  = idle_lvl;
    end
    if ((state == S_SETTLE) && (state_nx == S_LEAD)) begin
      lead_nx = rise;
      if (skew == '0) lag_nx = rise;
    end
    if (lag_fire) lag_nx = rise;
    a1_nx = a1_lead ? lead_nx : lag_nx;
    a2_nx = a1_lead ? lag_nx  : lead_nx;
    // Before the lead choice is latched only the common idle level can be driven
    if (state == S_IDLE) begin
      a1_nx = drive_idle ? idle_lvl : myinA1;
      a2_nx = drive_idle ? idle_lvl : myinA2;
    end
  end

  // State, configuration, counter and chain-input registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      skew      <= '0;
      skew_max  <= '0;
      skew_step <= '0;
      a1_lead   <= 1'b0;
      rise      <= 1'b0;
      cnt       <= '0;
      myinA1    <= 1'b0;
      myinA2    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_nx;
      myinA1 <= a1_nx;
      myinA2 <= a2_nx;
      busy   <= (state_nx != S_IDLE);
      done   <= (state_nx == S_FIN) && (state != S_FIN);
      if ((state == S_IDLE) && start) begin
        skew      <= cfg_skew_min;
        skew_max  <= cfg_skew_max;
        skew_step <= cfg_skew_step;
        a1_lead   <= cfg_a1_lead;
        rise      <= cfg_rise;
      end else if ((state == S_REPORT) && (state_nx == S_SETTLE)) begin
        skew <= next_skew[SKEW_W-1:0];
      end
      if (cnt_clr)       cnt <= '0;
      else if (!cnt_max) cnt <= cnt + CNT_W'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous chain output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= dut_out;
      sync2 <= sync1;
    end
  end

  // Hit capture and result registers; result fields freeze while in REPORT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit         <= 1'b0;
      res_valid   <= 1'b0;
      res_skew    <= '0;
      res_lat     <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= (state_nx == S_REPORT);
      if (state_nx == S_LEAD) begin
        hit <= 1'b0;
      end else if (hit_now) begin
        hit     <= 1'b1;
        res_lat <= cnt;
      end
      if ((state == S_MEAS) && (state_nx == S_REPORT)) begin
        res_skew    <= skew;
        res_timeout <= !(hit || hit_now);
        if (!(hit || hit_now)) res_lat <= CNT_W'(TIMEOUT);
      end
    end
  end

endmodule
